// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider / tick generator.
// Each channel runs a wrap counter; divisor changes are deferred to period boundaries.
module prog_clk_div #(
  parameter int N_CH    = 2,
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       clr,
  input  logic [N_CH*CNT_W-1:0] div_in,
  input  logic [N_CH-1:0]       div_load,
  output logic [N_CH-1:0]       tick_o,
  output logic [N_CH-1:0]       sq_o,
  output logic [N_CH-1:0]       pend_o
);

  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);

  // A programmed divisor of zero behaves as divide-by-one.
  function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] d);
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

  // ceil(d/2) kept in CNT_W bits: the largest result is 2^(CNT_W-1).
  function automatic logic [CNT_W-1:0] half_up(input logic [CNT_W-1:0] d);
    return (d >> 1) + CNT_W'(d[0]);
  endfunction

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic [CNT_W-1:0] div_new;
    logic [CNT_W-1:0] div_eff;
    logic             run;
    logic             wrap;

    assign div_new = div_in[g*CNT_W +: CNT_W];
    assign div_eff = eff_div(act_q);
    assign run     = en[g] & ~clr[g];
    assign wrap    = run & (cnt_q == div_eff - CNT_W'(1));

    always_comb begin
      cnt_d  = '0;
      tick_d = 1'b0;
      sq_d   = 1'b0;
      act_d  = act_q;
      pdiv_d = pdiv_q;
      pend_d = pend_q;
      if (run) begin
        cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
        tick_d = wrap;
        sq_d   = (cnt_d >= half_up(div_eff));
        // A load on the wrap edge itself is already at a boundary, so it skips the shadow.
        if (div_load[g]) begin
          if (wrap) begin
            act_d  = div_new;
            pend_d = 1'b0;
          end else begin
            pdiv_d = div_new;
            pend_d = 1'b1;
          end
        end else if (wrap && pend_q) begin
          act_d  = pdiv_q;
          pend_d = 1'b0;
        end
      end else begin
        // Stopped or cleared: the phase restarts here, which is itself a boundary.
        if (div_load[g]) begin
          act_d = div_new;
        end else if (pend_q) begin
          act_d = pdiv_q;
        end
        pend_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q  <= '0;
        act_q  <= DEF_DIV_C;
        pdiv_q <= '0;
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        pdiv_q <= pdiv_d;
        pend_q <= pend_d;
        tick_q <= tick_d;
        sq_q   <= sq_d;
      end
    end

    assign tick_o[g] = tick_q;
    assign sq_o[g]   = sq_q;
    assign pend_o[g] = pend_q;
  end

endmodule
